// File: rtl/async_latch_ctrl.sv
// Four-phase req/ack controller driving a latch capture handshake (ask/latched).
// Optional watchdog with sticky err and DRAIN state enabled by `define ASYNC_TIMEOUT_EN.
module async_latch_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef ASYNC_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic latched,
  output logic ask,
  output logic ack
`ifdef ASYNC_TIMEOUT_EN
  , output logic err
`endif
);

`ifdef ASYNC_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ASK   = 3'd1,
    LDONE = 3'd2,
    ACK   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ASK   = 2'd1,
    LDONE = 2'd2,
    ACK   = 2'd3
  } state_t;
`endif

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] latched_sync;
  logic                   req_s;
  logic                   latched_s;

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign latched_s = latched_sync[SYNC_STAGES-1];

  // Input synchronisers; bit 0 samples the raw asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_sync     <= '0;
      latched_sync <= '0;
    end else begin
      req_sync[0]     <= req;
      latched_sync[0] <= latched;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        req_sync[i]     <= req_sync[i-1];
        latched_sync[i] <= latched_sync[i-1];
      end
    end
  end

`ifdef ASYNC_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_c;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent waiting in ASK/LDONE; any state change restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      if ((state_d != state_q) || !((state_q == ASK) || (state_q == LDONE))) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_d == DRAIN) && (state_q != DRAIN)) begin
        err <= 1'b1;
      end
    end
  end
`endif

  // Next-state logic on synchronised inputs only.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_s) state_d = ASK;
`ifdef ASYNC_TIMEOUT_EN
      ASK: begin
        if (latched_s)      state_d = LDONE;
        else if (timeout_c) state_d = DRAIN;
      end
      LDONE: begin
        if (!latched_s)     state_d = ACK;
        else if (timeout_c) state_d = DRAIN;
      end
      DRAIN: if (!req_s) state_d = IDLE;
`else
      ASK:   if (latched_s) state_d = LDONE;
      LDONE: if (!latched_s) state_d = ACK;
`endif
      ACK:   if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ask     <= 1'b0;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      ask     <= (state_d == ASK);
      ack     <= (state_d == ACK);
    end
  end

endmodule

// File: tb/tb_async_latch_ctrl.sv
// Directed self-checking bench for async_latch_ctrl with SYNC_STAGES=2.
// Timeout scenario is exercised when ASYNC_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_async_latch_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req = 1'b0;
  logic latched = 1'b0;
  logic ask;
  logic ack;
`ifdef ASYNC_TIMEOUT_EN
  logic err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ask_pulses = 0;
  logic ask_prev = 1'b0;
  logic overlap_seen = 1'b0;

  always #5 clk = ~clk;

`ifdef ASYNC_TIMEOUT_EN
  async_latch_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .latched(latched),
    .ask(ask), .ack(ack), .err(err)
  );
`else
  async_latch_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .latched(latched),
    .ask(ask), .ack(ack)
  );
`endif

  // Mid-cycle monitor: ask rising edges and ask/ack overlap.
  always @(negedge clk) begin
    if (ask && ack) overlap_seen <= 1'b1;
    if (ask && !ask_prev) ask_pulses <= ask_pulses + 1;
    ask_prev <= ask;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Finishes a transaction already in ASK: latched held 4 cycles, then req drop.
  task automatic finish_txn();
    latched = 1'b1; tick(4);
    latched = 1'b0; tick(4);
    req = 1'b0;     tick(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b1; latched = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_checks++;
      if (ask !== 1'b0 || ack !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold cycle %0d: ask=%b ack=%b, expected 0 0", i, ask, ack);
      end
    end
`ifdef ASYNC_TIMEOUT_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: err=%b, expected 0", err);
    end
`endif
    latched = 1'b0;
    reset_n = 1'b1;
    tick(2);
    n_checks++;
    if (ask !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_early: ask=%b after 2 edges, expected 0", ask);
    end
    tick(1);
    n_checks++;
    if (ask !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ask: ask=%b after 3 edges, expected 1", ask);
    end
    finish_txn();
  endtask

  task automatic test_nominal();
    req = 1'b1; tick(2);
    n_checks++;
    if (ask !== 1'b0) begin
      n_fail++; $display("FAIL nom_ask_early: ask=%b, expected 0", ask);
    end
    tick(1);
    n_checks++;
    if (ask !== 1'b1) begin
      n_fail++; $display("FAIL nom_ask_rise: ask=%b, expected 1", ask);
    end
    latched = 1'b1; tick(2);
    n_checks++;
    if (ask !== 1'b1) begin
      n_fail++; $display("FAIL nom_ask_hold: ask=%b, expected 1", ask);
    end
    tick(1);
    n_checks++;
    if (ask !== 1'b0 || ack !== 1'b0) begin
      n_fail++; $display("FAIL nom_ask_fall: ask=%b ack=%b, expected 0 0", ask, ack);
    end
    tick(1);
    latched = 1'b0; tick(2);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++; $display("FAIL nom_ack_early: ack=%b, expected 0", ack);
    end
    tick(1);
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++; $display("FAIL nom_ack_rise: ack=%b, expected 1", ack);
    end
    req = 1'b0; tick(2);
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++; $display("FAIL nom_ack_hold: ack=%b, expected 1", ack);
    end
    tick(1);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++; $display("FAIL nom_ack_fall: ack=%b, expected 0", ack);
    end
  endtask

  task automatic test_back_to_back();
    int start_pulses;
    tick(2);
    start_pulses = ask_pulses;
    for (int t = 0; t < 2; t++) begin
      req = 1'b1; tick(3);
      n_checks++;
      if (ask !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ask txn %0d: ask=%b, expected 1", t, ask);
      end
      latched = 1'b1; tick(4);
      latched = 1'b0; tick(3);
      n_checks++;
      if (ack !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ack txn %0d: ack=%b, expected 1", t, ack);
      end
      req = 1'b0; tick(3);
      n_checks++;
      if (ack !== 1'b0) begin
        n_fail++; $display("FAIL b2b_ack_fall txn %0d: ack=%b, expected 0", t, ack);
      end
      tick(1);
    end
    n_checks++;
    if (ask_pulses - start_pulses !== 2) begin
      n_fail++; $display("FAIL b2b_pulses: counted %0d ask pulses, expected 2", ask_pulses - start_pulses);
    end
  endtask

  task automatic test_spurious_latched();
    logic seen;
    seen = 1'b0;
    req = 1'b0; latched = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) latched = 1'b0;
      tick(1);
      if (ask !== 1'b0 || ack !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL spurious_idle: ask/ack activity=%b, expected 0", seen);
    end
    req = 1'b1; tick(3);
    n_checks++;
    if (ask !== 1'b1) begin
      n_fail++; $display("FAIL spurious_after_ask: ask=%b, expected 1", ask);
    end
    latched = 1'b1; tick(4);
    latched = 1'b0; tick(3);
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++; $display("FAIL spurious_after_ack: ack=%b, expected 1", ack);
    end
    req = 1'b0; tick(4);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; tick(3);
    n_checks++;
    if (ask !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ask: ask=%b, expected 1", ask);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ask !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: ask=%b before next edge, expected 0", ask);
    end
    req = 1'b0; latched = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    n_checks++;
    if (ask !== 1'b0 || ack !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: ask=%b ack=%b, expected 0 0", ask, ack);
    end
  endtask

`ifdef ASYNC_TIMEOUT_EN
  task automatic test_timeout();
    req = 1'b1; tick(3);
    n_checks++;
    if (ask !== 1'b1) begin
      n_fail++; $display("FAIL to_ask: ask=%b, expected 1", ask);
    end
    tick(7);
    n_checks++;
    if (err !== 1'b0 || ask !== 1'b1) begin
      n_fail++; $display("FAIL to_early: err=%b ask=%b, expected 0 1", err, ask);
    end
    tick(1);
    n_checks++;
    if (err !== 1'b1 || ask !== 1'b0) begin
      n_fail++; $display("FAIL to_fire: err=%b ask=%b, expected 1 0", err, ask);
    end
    req = 1'b0; tick(4);
    req = 1'b1; tick(3);
    n_checks++;
    if (ask !== 1'b1) begin
      n_fail++; $display("FAIL to_restart: ask=%b, expected 1", ask);
    end
    latched = 1'b1; tick(4);
    latched = 1'b0; tick(3);
    n_checks++;
    if (ack !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL to_complete: ack=%b err=%b, expected 1 1", ack, err);
    end
    req = 1'b0; tick(4);
  endtask
`endif

  task automatic test_exclusive();
    n_checks++;
    if (overlap_seen !== 1'b0) begin
      n_fail++; $display("FAIL exclusive: ask and ack seen high together=%b, expected 0", overlap_seen);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_spurious_latched();
    test_reset_mid();
`ifdef ASYNC_TIMEOUT_EN
    test_timeout();
`endif
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
